// File: rtl/mm_stream_reader.sv
// mm_stream_reader: streams len words from a 1-cycle-latency RAM onto AXI-Stream
// through a 2-entry skid FIFO, issuing reads only when a free slot is guaranteed.
module mm_stream_reader #(
    parameter int SIZE       = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  clr,
    input  logic [SIZE-1:0]       len,
    output logic                  mem_en,
    output logic [SIZE-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t                state;
    logic [SIZE-1:0]       len_q, rd_addr, beat;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0]            occ;
    logic                  infl, rp, wp, pop;
    logic [2:0]            lvl;

    assign m_axis_tvalid = occ != 2'd0;
    assign m_axis_tdata  = fifo[rp];
    assign m_axis_tlast  = m_axis_tvalid && beat == len_q - SIZE'(1);
    assign pop           = m_axis_tvalid && m_axis_tready;
    // Projected FIFO level once the in-flight word lands and this cycle's pop retires
    assign lvl           = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    assign mem_en        = state == READ && !clr && rd_addr < len_q && lvl < 3'd2;
    assign mem_addr      = rd_addr;
    assign busy          = state != IDLE;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            len_q   <= '0;
            rd_addr <= '0;
            beat    <= '0;
            occ     <= '0;
            infl    <= 1'b0;
            rp      <= 1'b0;
            wp      <= 1'b0;
            done    <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else if (clr) begin
            state   <= IDLE;
            rd_addr <= '0;
            beat    <= '0;
            occ     <= '0;
            infl    <= 1'b0;
            rp      <= 1'b0;
            wp      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            infl <= mem_en;
            occ  <= occ + {1'b0, infl} - {1'b0, pop};
            if (infl) begin
                fifo[wp] <= mem_rdata;
                wp       <= ~wp;
            end
            if (pop) begin
                rp   <= ~rp;
                beat <= beat + SIZE'(1);
            end
            if (mem_en)
                rd_addr <= rd_addr + SIZE'(1);
            case (state)
                IDLE: begin
                    if (start && len == '0)
                        done <= 1'b1;
                    else if (start) begin
                        len_q   <= len;
                        rd_addr <= '0;
                        beat    <= '0;
                        state   <= READ;
                    end
                end
                READ: if (mem_en && rd_addr + SIZE'(1) == len_q) state <= DRAIN;
                DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
